// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 key decoder: prefix bytes, discard list,
// prefix FSM states and the set-2 to ASCII table.
package ps2_pkg;

  localparam logic [7:0] PS2_E0 = 8'hE0;
  localparam logic [7:0] PS2_F0 = 8'hF0;
  localparam int         EVT_W  = 10;

  // Keyboard status/ack bytes that never start a scan code
  localparam logic [7:0] DISCARD_BYTES [6] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

  typedef enum logic [1:0] {ST_IDLE, ST_E0, ST_F0, ST_E0F0} ps2_state_t;

  function automatic logic is_discard(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (b == DISCARD_BYTES[i]) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic [7:0] set2_to_ascii(input logic [7:0] code);
    case (code)
      8'h1C: return 8'h61; 8'h32: return 8'h62; 8'h21: return 8'h63; 8'h23: return 8'h64;
      8'h24: return 8'h65; 8'h2B: return 8'h66; 8'h34: return 8'h67; 8'h33: return 8'h68;
      8'h43: return 8'h69; 8'h3B: return 8'h6A; 8'h42: return 8'h6B; 8'h4B: return 8'h6C;
      8'h3A: return 8'h6D; 8'h31: return 8'h6E; 8'h44: return 8'h6F; 8'h4D: return 8'h70;
      8'h15: return 8'h71; 8'h2D: return 8'h72; 8'h1B: return 8'h73; 8'h2C: return 8'h74;
      8'h3C: return 8'h75; 8'h2A: return 8'h76; 8'h1D: return 8'h77; 8'h22: return 8'h78;
      8'h35: return 8'h79; 8'h1A: return 8'h7A;
      8'h45: return 8'h30; 8'h16: return 8'h31; 8'h1E: return 8'h32; 8'h26: return 8'h33;
      8'h25: return 8'h34; 8'h2E: return 8'h35; 8'h36: return 8'h36; 8'h3D: return 8'h37;
      8'h3E: return 8'h38; 8'h46: return 8'h39;
      8'h29: return 8'h20;
      8'h5A: return 8'h0D;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// First-word fall-through event queue; a push into a full queue is accepted
// only when a pop happens on the same cycle.
module ps2_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_rd, do_wr;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (do_wr && !do_rd)      count_reg <= count_reg + 1'b1;
      else if (do_rd && !do_wr) count_reg <= count_reg - 1'b1;
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 byte stream to key event decoder with event queue and held-key
// tracking. Define PS2_KEY_ASCII_EN to add the evt_ascii output.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH      = 8,
  parameter int CNT_W           = 8,
  parameter int SUPPRESS_REPEAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       ps2_data,
  input  logic             ps2_ready,
  output logic             ps2_nextdata_n,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_break,
  output logic [CNT_W-1:0] press_cnt,
  output logic             key_held,
  output logic             ovf
`ifdef PS2_KEY_ASCII_EN
  , output logic [7:0]     evt_ascii
`endif
);

  ps2_state_t       state_reg, state_next;
  logic             pop_reg;
  logic             evt_done, evt_ext_c, evt_brk_c;
  logic             held_reg;
  logic [8:0]       held_key_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             ovf_reg;
  logic             held_match, suppress, push_req, push_ok;
  logic             fifo_pop, fifo_empty, fifo_full;
  logic [EVT_W-1:0] head;

  // Registered strobe: a pop cycle is always followed by at least one idle cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pop_reg <= 1'b0;
    else     pop_reg <= ps2_ready && !pop_reg;
  end
  assign ps2_nextdata_n = ~pop_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    evt_done   = 1'b0;
    evt_ext_c  = 1'b0;
    evt_brk_c  = 1'b0;
    if (pop_reg) begin
      case (state_reg)
        ST_IDLE: begin
          if (ps2_data == PS2_E0)      state_next = ST_E0;
          else if (ps2_data == PS2_F0) state_next = ST_F0;
          else if (!is_discard(ps2_data)) evt_done = 1'b1;
        end
        ST_E0: begin
          if (ps2_data == PS2_F0) state_next = ST_E0F0;
          else if (ps2_data != PS2_E0) begin
            evt_done = 1'b1; evt_ext_c = 1'b1; state_next = ST_IDLE;
          end
        end
        ST_F0: begin
          if (ps2_data != PS2_F0) begin
            evt_done = 1'b1; evt_brk_c = 1'b1; state_next = ST_IDLE;
          end
        end
        ST_E0F0: begin
          if (ps2_data != PS2_F0) begin
            evt_done = 1'b1; evt_ext_c = 1'b1; evt_brk_c = 1'b1; state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign held_match = held_reg && (held_key_reg == {evt_ext_c, ps2_data});
  assign suppress   = (SUPPRESS_REPEAT != 0) && !evt_brk_c && held_match;
  assign push_req   = evt_done && !suppress;
  assign fifo_pop   = evt_valid && evt_ready;
  assign push_ok    = push_req && (!fifo_full || fifo_pop);

  ps2_evt_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EVT_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_req),
    .wr_data ({evt_ext_c, evt_brk_c, ps2_data}),
    .rd_en   (fifo_pop),
    .rd_data (head),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // Held-key state follows the keyboard, independent of queue space
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_reg     <= 1'b0;
      held_key_reg <= '0;
      cnt_reg      <= '0;
      ovf_reg      <= 1'b0;
    end else begin
      if (evt_done && !evt_brk_c && !suppress) begin
        held_reg     <= 1'b1;
        held_key_reg <= {evt_ext_c, ps2_data};
      end else if (evt_done && evt_brk_c && held_match) begin
        held_reg <= 1'b0;
      end
      if (push_ok && !evt_brk_c) cnt_reg <= cnt_reg + CNT_W'(1);
      if (push_req && !push_ok)  ovf_reg <= 1'b1;
    end
  end

  assign evt_valid = !fifo_empty;
  assign evt_ext   = evt_valid & head[9];
  assign evt_break = evt_valid & head[8];
  assign evt_code  = evt_valid ? head[7:0] : 8'h00;
  assign press_cnt = cnt_reg;
  assign key_held  = held_reg;
  assign ovf       = ovf_reg;

`ifdef PS2_KEY_ASCII_EN
  assign evt_ascii = (evt_valid && !head[9]) ? set2_to_ascii(head[7:0]) : 8'h00;
`endif

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed scoreboard bench: instance a uses defaults, instance b uses
// SUPPRESS_REPEAT=0 and CNT_W=4.
module tb_ps2_key_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] data_a = 8'h00, data_b = 8'h00;
  logic       rdy_a = 1'b0, rdy_b = 1'b0;
  logic       nd_a, nd_b;
  logic       er_a = 1'b1, er_b = 1'b1;
  logic       v_a, v_b, ext_a, ext_b, brk_a, brk_b;
  logic [7:0] code_a, code_b;
  logic [7:0] cnt_a;
  logic [3:0] cnt_b;
  logic       held_a, held_b, ovf_a, ovf_b;
`ifdef PS2_KEY_ASCII_EN
  logic [7:0] ascii_a, ascii_b;
`endif

  int checks = 0;
  int errors = 0;

  ps2_key_decoder dut_a (
`ifdef PS2_KEY_ASCII_EN
    .evt_ascii(ascii_a),
`endif
    .clk(clk), .rst(rst), .ps2_data(data_a), .ps2_ready(rdy_a), .ps2_nextdata_n(nd_a),
    .evt_valid(v_a), .evt_ready(er_a), .evt_code(code_a), .evt_ext(ext_a), .evt_break(brk_a),
    .press_cnt(cnt_a), .key_held(held_a), .ovf(ovf_a)
  );

  ps2_key_decoder #(.SUPPRESS_REPEAT(0), .CNT_W(4)) dut_b (
`ifdef PS2_KEY_ASCII_EN
    .evt_ascii(ascii_b),
`endif
    .clk(clk), .rst(rst), .ps2_data(data_b), .ps2_ready(rdy_b), .ps2_nextdata_n(nd_b),
    .evt_valid(v_b), .evt_ready(er_b), .evt_code(code_b), .evt_ext(ext_b), .evt_break(brk_b),
    .press_cnt(cnt_b), .key_held(held_b), .ovf(ovf_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Upstream receiver queues: a strobe seen at one falling edge removes the head at the next
  logic [7:0] qa[$], qb[$];
  bit pend_a = 1'b0, pend_b = 1'b0;
  always @(negedge clk) begin
    if (pend_a) begin void'(qa.pop_front()); pend_a = 1'b0; end
    else if (!nd_a) pend_a = 1'b1;
    rdy_a  = (qa.size() != 0);
    data_a = rdy_a ? qa[0] : 8'h00;
    if (pend_b) begin void'(qb.pop_front()); pend_b = 1'b0; end
    else if (!nd_b) pend_b = 1'b1;
    rdy_b  = (qb.size() != 0);
    data_b = rdy_b ? qb[0] : 8'h00;
  end

  // Scoreboards: expected {ext, break, code} per instance, compared on each pop
  logic [9:0] ea[$], eb[$];
  always @(negedge clk) begin
    if (!rst && v_a && er_a) begin
      checks++;
      assert (ea.size() != 0) else begin
        errors++;
        $error("FAIL evt_a_extra observed=%0h expected=none", {ext_a, brk_a, code_a});
      end
      if (ea.size() != 0) chk("evt_a", {22'd0, ext_a, brk_a, code_a}, {22'd0, ea.pop_front()});
    end
    if (!rst && v_b && er_b) begin
      checks++;
      assert (eb.size() != 0) else begin
        errors++;
        $error("FAIL evt_b_extra observed=%0h expected=none", {ext_b, brk_b, code_b});
      end
      if (eb.size() != 0) chk("evt_b", {22'd0, ext_b, brk_b, code_b}, {22'd0, eb.pop_front()});
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_bytes();
    int n = 0;
    while ((qa.size() != 0 || pend_a || qb.size() != 0 || pend_b) && n < 400) begin
      tick(); n++;
    end
    chk("bytes_timeout", {31'd0, n < 400}, 32'd1);
    tick(3);
  endtask

  task automatic wait_events();
    int n = 0;
    while ((ea.size() != 0 || eb.size() != 0) && n < 400) begin
      tick(); n++;
    end
    chk("events_timeout", {31'd0, n < 400}, 32'd1);
    tick(2);
  endtask

  task automatic check_reset_a(input string tag);
    chk({tag, "_valid"}, {31'd0, v_a}, 32'd0);
    chk({tag, "_code"}, {22'd0, ext_a, brk_a, code_a}, 32'd0);
    chk({tag, "_cnt"}, {24'd0, cnt_a}, 32'd0);
    chk({tag, "_held"}, {31'd0, held_a}, 32'd0);
    chk({tag, "_ovf"}, {31'd0, ovf_a}, 32'd0);
    chk({tag, "_nd"}, {31'd0, nd_a}, 32'd1);
  endtask

  logic [7:0] keys [9];

  initial begin
    keys = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};

    // Reset values
    tick(3);
    check_reset_a("rst_a");
    chk("rst_b_cnt", {28'd0, cnt_b}, 32'd0);
    chk("rst_b_valid", {31'd0, v_b}, 32'd0);
    rst = 1'b0;
    tick(2);

    // Make then break of 1C
    qa.push_back(8'h1C); ea.push_back({2'b00, 8'h1C});
    wait_bytes();
    chk("held_after_make", {31'd0, held_a}, 32'd1);
    qa.push_back(8'hF0); qa.push_back(8'h1C); ea.push_back({2'b01, 8'h1C});
    wait_bytes(); wait_events();
    chk("held_after_break", {31'd0, held_a}, 32'd0);
    chk("cnt_after_1c", {24'd0, cnt_a}, 32'd1);

    // Extended key with redundant E0 before the break prefix
    foreach (qa[i]) ;
    qa.push_back(8'hE0); qa.push_back(8'h75); qa.push_back(8'hE0); qa.push_back(8'hF0); qa.push_back(8'h75);
    ea.push_back({2'b10, 8'h75}); ea.push_back({2'b11, 8'h75});
    wait_bytes(); wait_events();
    chk("cnt_after_ext", {24'd0, cnt_a}, 32'd2);

    // Typematic repeats: suppressed on a, kept on b
    for (int i = 0; i < 3; i++) begin qa.push_back(8'h1C); qb.push_back(8'h1C); end
    qa.push_back(8'hF0); qa.push_back(8'h1C); qb.push_back(8'hF0); qb.push_back(8'h1C);
    ea.push_back({2'b00, 8'h1C}); ea.push_back({2'b01, 8'h1C});
    for (int i = 0; i < 3; i++) eb.push_back({2'b00, 8'h1C});
    eb.push_back({2'b01, 8'h1C});
    wait_bytes(); wait_events();
    chk("cnt_a_repeat", {24'd0, cnt_a}, 32'd3);
    chk("cnt_b_repeat", {28'd0, cnt_b}, 32'd3);
    chk("held_b_repeat", {31'd0, held_b}, 32'd0);

    // Nine distinct makes into a stalled queue of eight
    er_a = 1'b0;
    for (int i = 0; i < 9; i++) begin
      qa.push_back(keys[i]);
      if (i < 8) ea.push_back({2'b00, keys[i]});
    end
    wait_bytes();
    chk("ovf_full", {31'd0, ovf_a}, 32'd1);
    chk("cnt_full", {24'd0, cnt_a}, 32'd11);
    chk("valid_full", {31'd0, v_a}, 32'd1);
    chk("head_full", {22'd0, ext_a, brk_a, code_a}, {24'd0, keys[0]});
    er_a = 1'b1;
    wait_events();
    chk("valid_drained", {31'd0, v_a}, 32'd0);
    chk("ovf_sticky", {31'd0, ovf_a}, 32'd1);
    chk("code_drained", {24'd0, code_a}, 32'd0);

    // Reset while the FSM sits in E0F0
    qa.push_back(8'hE0); qa.push_back(8'hF0);
    wait_bytes();
    rst = 1'b1;
    #1;
    check_reset_a("async_rst_a");
    tick(2);
    rst = 1'b0;
    tick(2);
    qa.push_back(8'h1C); ea.push_back({2'b00, 8'h1C});
    wait_bytes(); wait_events();
    chk("cnt_after_rst", {24'd0, cnt_a}, 32'd1);

    // AA in IDLE produces nothing; 17 press/release pairs wrap the 4-bit counter
    qa.push_back(8'hAA);
    for (int i = 0; i < 17; i++) begin
      qb.push_back(8'h15); qb.push_back(8'hF0); qb.push_back(8'h15);
      eb.push_back({2'b00, 8'h15}); eb.push_back({2'b01, 8'h15});
    end
    wait_bytes(); wait_events();
    chk("aa_no_event", {31'd0, v_a}, 32'd0);
    chk("aa_cnt", {24'd0, cnt_a}, 32'd1);
    chk("cnt_b_wrap", {28'd0, cnt_b}, 32'd1);
    chk("held_b_wrap", {31'd0, held_b}, 32'd0);
    chk("ovf_b", {31'd0, ovf_b}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, event FIFO depth; power of two, 2..64.
REQ-002 SHALL have parameter CNT_W, default 8, press-counter width.
REQ-003 SHALL have parameter SUPPRESS_REPEAT, default 1; 1 = drop typematic repeats of the held key.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port ps2_data  in  8  byte at the head of the upstream PS/2 receiver queue.
REQ-007 SHALL have port ps2_ready  in  1  upstream queue non-empty.
REQ-008 SHALL have port ps2_nextdata_n  out  1  active-low one-cycle pop strobe to upstream.
REQ-009 SHALL have port evt_valid  out  1  event FIFO non-empty.
REQ-010 SHALL have port evt_ready  in  1  consumer pops the head event.
REQ-011 SHALL have port evt_code  out  8  head event scan code (prefixes stripped).
REQ-012 SHALL have port evt_ext  out  1  head event carried an E0 prefix.
REQ-013 SHALL have port evt_break  out  1  head event is a release (F0 seen).
REQ-014 SHALL have port press_cnt  out  CNT_W  count of enqueued make events.
REQ-015 SHALL have port key_held  out  1  a key is currently held.
REQ-016 SHALL have port ovf  out  1  sticky: completed event dropped because FIFO was full.

Function
REQ-017 SHALL consume a byte when ps2_ready=1 and no pop is in flight: ps2_nextdata_n low exactly one cycle, then high for at least one cycle before the next pop.
REQ-018 SHALL use a prefix FSM with states IDLE, E0, F0, E0F0: IDLE+E0->E0; IDLE+F0->F0; E0+F0->E0F0; any other byte completes a code and returns to IDLE.
REQ-019 SHALL discard, in IDLE only, bytes 0x00, 0xAA, 0xEE, 0xFA, 0xFE, 0xFF without state change.
REQ-020 SHALL treat a repeated E0 in state E0 as a no-op, and F0 in state F0 or E0F0 as a no-op.
REQ-021 SHALL form each completed code into {ext, break, code}, ext/break taken from the state it completes in.
REQ-022 SHALL, with SUPPRESS_REPEAT=1, drop a make whose {ext,code} equals the held key while key_held=1.
REQ-023 SHALL, on an accepted make, set key_held=1 and record {ext,code}; on a break matching the held key, clear key_held; on a non-matching break, leave the held key unchanged.
REQ-024 SHALL enqueue non-dropped events; the event is visible at the FIFO outputs on the cycle after the completing byte is popped.
REQ-025 SHALL, if the FIFO is full when an event completes, drop the event, set ovf, and leave press_cnt unchanged; the FSM still returns to IDLE.
REQ-026 SHALL pop the FIFO on evt_valid & evt_ready; evt_ready with evt_valid=0 is ignored; simultaneous push and pop on a full FIFO succeeds, and the occupancy stays FIFO_DEPTH.
REQ-027 SHALL increment press_cnt, modulo 2^CNT_W, once per enqueued make event; no increment for breaks or suppressed repeats.
REQ-028 SHALL present evt_code/evt_ext/evt_break as 0 when evt_valid=0.

Reset
REQ-029 SHALL on rst, at any time including mid-prefix: FSM to IDLE, FIFO empty, evt_valid=0, press_cnt=0, key_held=0, ovf=0, ps2_nextdata_n=1, event outputs 0.
REQ-030 SHALL clear ovf only by reset.

Configuration
REQ-031 SHALL, with PS2_KEY_ASCII_EN defined, add output evt_ascii (8) giving the US-layout ASCII value of the head event's non-extended set-2 code (letters lowercase, digits, space 0x20, enter 0x0D), and 0x00 for extended or unmapped codes.
REQ-032 SHALL, without PS2_KEY_ASCII_EN, omit evt_ascii and the translation logic entirely.

Structure
REQ-033 SHALL place prefix constants (0xE0, 0xF0), the discard-byte list, the FSM state enum and the ASCII table function in shared package ps2_pkg.
REQ-034 SHALL implement the event queue as sub-module ps2_evt_fifo (parameter DEPTH, WIDTH=10), first-word fall-through.

Verification
REQ-035 SHALL cover: bytes 1C, F0, 1C with evt_ready=1 -> events {0,0,1C}, {0,1,1C}; press_cnt=1; key_held 1 then 0.
REQ-036 SHALL cover: bytes E0, 75, E0, F0, 75 -> events {1,0,75}, {1,1,75}; ext set on both.
REQ-037 SHALL cover: with SUPPRESS_REPEAT=1, bytes 1C, 1C, 1C, F0, 1C -> two events only; press_cnt=1; with SUPPRESS_REPEAT=0 -> four events, press_cnt=3.
REQ-038 SHALL cover: evt_ready=0, FIFO_DEPTH=8, nine distinct makes -> 8 queued, ovf=1, press_cnt=8; then drain -> 8 pops in order, evt_valid=0.
REQ-039 SHALL cover: rst asserted after E0, F0 -> all outputs at reset values; a following 1C yields {0,0,1C}.
REQ-040 SHALL cover: CNT_W=4, seventeen press/release pairs -> press_cnt wraps to 1; byte AA in IDLE -> no event.
